// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
// Entry field widths follow the defaults below; override them together with the module parameters.
package hazard_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int DEPTH_DEF  = 3;
  localparam int LAT_W_DEF  = 3;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  v;
    logic                  wr;
    logic [REG_AW_DEF-1:0] rd;
    logic [LAT_W_DEF-1:0]  lat;
  } sb_entry_t;
endpackage

// File: rtl/hazard_port_match.sv
// Per-read-port search of the scoreboard: youngest matching producer picks
// the forward stage, or flags not-ready if its result is not yet available.
module hazard_port_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LAT_W  = LAT_W_DEF,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0]    rs_i,
  input  logic                 used_i,
  input  sb_entry_t [DEPTH:1]  sb_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 not_ready_o
);

  logic found;

  always_comb begin
    sel_o       = SEL_W'(FWD_RF);
    not_ready_o = 1'b0;
    found       = 1'b0;
    // Ascending scan so the first hit is the youngest producer.
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && used_i && (rs_i != '0) && sb_i[k].v && sb_i[k].wr &&
          (sb_i[k].rd == rs_i)) begin
        found = 1'b1;
        if (LAT_W'(k) >= sb_i[k].lat) begin
          sel_o = SEL_W'(k);
        end else begin
          not_ready_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding and hazard unit: shift scoreboard of in-flight writers behind ID,
// per-port forward select, load-use stall and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int NUM_RD_PORTS = 2,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int LAT_W        = LAT_W_DEF,
  parameter int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           id_valid_i,
  input  logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_i,
  input  logic [NUM_RD_PORTS-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]              id_rd_i,
  input  logic                           id_reg_write_i,
  input  logic [LAT_W-1:0]               id_lat_i,
  input  logic                           flush_i,
  output logic                           stall_o,
  output logic [NUM_RD_PORTS*SEL_W-1:0]  fwd_sel_o,
  output logic [31:0]                    stall_cnt_o
);

  sb_entry_t [DEPTH:1]     sb_q, sb_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d;
  logic [NUM_RD_PORTS-1:0] not_ready;
  logic                    raw_stall;
  logic                    issue;
  logic [LAT_W-1:0]        lat_norm;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    hazard_port_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .LAT_W  (LAT_W),
      .SEL_W  (SEL_W)
    ) u_match (
      .rs_i        (id_rs_i[p*REG_AW +: REG_AW]),
      .used_i      (id_rs_used_i[p]),
      .sb_i        (sb_q),
      .sel_o       (fwd_sel_o[p*SEL_W +: SEL_W]),
      .not_ready_o (not_ready[p])
    );
  end

  assign raw_stall = |not_ready;
  // Flush kills the ID instruction, so it can never be the one holding IF/ID.
  assign stall_o   = raw_stall & id_valid_i & ~flush_i;
  assign issue     = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    lat_norm = id_lat_i;
    if (id_lat_i == '0) begin
      lat_norm = LAT_W'(1);
    end else if (id_lat_i > LAT_W'(DEPTH)) begin
      lat_norm = LAT_W'(DEPTH);
    end
  end

  always_comb begin
    sb_d = sb_q;
    for (int k = DEPTH; k >= 2; k--) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[1] = '0;
    if (issue) begin
      sb_d[1].v   = 1'b1;
      sb_d[1].wr  = id_reg_write_i;
      sb_d[1].rd  = id_rd_i;
      sb_d[1].lat = lat_norm;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs are queued as each
// step is driven and compared when the DUT outputs settle.
module tb_hazard_scoreboard;
  localparam int REG_AW = 5;
  localparam int NRP    = 2;
  localparam int DEPTH  = 3;
  localparam int LAT_W  = 3;
  localparam int SEL_W  = 2;
  localparam int EXP_W  = 1 + NRP*SEL_W + 32;

  logic                  clk;
  logic                  rst_n;
  logic                  id_valid;
  logic [NRP*REG_AW-1:0] id_rs;
  logic [NRP-1:0]        id_rs_used;
  logic [REG_AW-1:0]     id_rd;
  logic                  id_reg_write;
  logic [LAT_W-1:0]      id_lat;
  logic                  flush;
  logic                  stall;
  logic [NRP*SEL_W-1:0]  fwd_sel;
  logic [31:0]           stall_cnt;

  logic [EXP_W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_scoreboard #(
    .REG_AW       (REG_AW),
    .NUM_RD_PORTS (NRP),
    .DEPTH        (DEPTH),
    .LAT_W        (LAT_W),
    .SEL_W        (SEL_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rs_used_i   (id_rs_used),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_lat_i       (id_lat),
    .flush_i        (flush),
    .stall_o        (stall),
    .fwd_sel_o      (fwd_sel),
    .stall_cnt_o    (stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic v, input logic [REG_AW-1:0] rs0, input logic [REG_AW-1:0] rs1,
                       input logic [1:0] used, input logic [REG_AW-1:0] rd, input logic wr,
                       input logic [LAT_W-1:0] lat, input logic fl);
    id_valid     = v;
    id_rs        = {rs1, rs0};
    id_rs_used   = used;
    id_rd        = rd;
    id_reg_write = wr;
    id_lat       = lat;
    flush        = fl;
  endtask

  task automatic push_exp(input logic e_stall, input logic [SEL_W-1:0] e_sel0,
                          input logic [SEL_W-1:0] e_sel1, input logic [31:0] e_cnt);
    exp_q.push_back({e_stall, e_sel1, e_sel0, e_cnt});
  endtask

  // Scoreboard compare
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic check_now(input int idx);
    logic [EXP_W-1:0] e;
    logic             e_stall;
    logic [SEL_W-1:0] e_sel0, e_sel1;
    logic [31:0]      e_cnt;
    if (exp_q.size() == 0) begin
      cmp($sformatf("s%0d.queue_empty", idx), 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    e_stall = e[EXP_W-1];
    e_sel1  = e[32+SEL_W +: SEL_W];
    e_sel0  = e[32 +: SEL_W];
    e_cnt   = e[31:0];
    cmp($sformatf("s%0d.stall", idx), {31'd0, stall}, {31'd0, e_stall});
    if (!e_stall) begin
      cmp($sformatf("s%0d.sel0", idx), {30'd0, fwd_sel[0 +: SEL_W]}, {30'd0, e_sel0});
      cmp($sformatf("s%0d.sel1", idx), {30'd0, fwd_sel[SEL_W +: SEL_W]}, {30'd0, e_sel1});
    end
    cmp($sformatf("s%0d.cnt", idx), stall_cnt, e_cnt);
  endtask

  // One ID cycle: drive after the edge, check at the falling edge, advance.
  task automatic step(input int idx, input logic v, input logic [REG_AW-1:0] rs0,
                      input logic [REG_AW-1:0] rs1, input logic [1:0] used,
                      input logic [REG_AW-1:0] rd, input logic wr, input logic [LAT_W-1:0] lat,
                      input logic fl, input logic e_stall, input logic [SEL_W-1:0] e_sel0,
                      input logic [SEL_W-1:0] e_sel1, input logic [31:0] e_cnt);
    drive(v, rs0, rs1, used, rd, wr, lat, fl);
    push_exp(e_stall, e_sel0, e_sel1, e_cnt);
    @(negedge clk);
    check_now(idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 3'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    //    idx v  rs0    rs1    used   rd     wr    lat   fl    stall sel0  sel1  cnt
    step(0,  1, 5'd5,  5'd6,  2'b11, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
    step(1,  1, 5'd0,  5'd0,  2'b00, 5'd5,  1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
    step(2,  1, 5'd5,  5'd0,  2'b01, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd1, 2'd0, 32'd0);
    step(3,  1, 5'd5,  5'd0,  2'b01, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd2, 2'd0, 32'd0);
    step(4,  1, 5'd0,  5'd0,  2'b00, 5'd7,  1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);
    step(5,  1, 5'd7,  5'd7,  2'b10, 5'd8,  1'b1, 3'd1, 1'b0, 1'b1, 2'd0, 2'd0, 32'd0);
    step(6,  1, 5'd7,  5'd7,  2'b10, 5'd8,  1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd2, 32'd1);
    step(7,  1, 5'd0,  5'd0,  2'b00, 5'd3,  1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd1);
    step(8,  1, 5'd0,  5'd0,  2'b00, 5'd3,  1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd1);
    step(9,  1, 5'd3,  5'd0,  2'b01, 5'd0,  1'b1, 3'd1, 1'b0, 1'b0, 2'd1, 2'd0, 32'd1);
    step(10, 1, 5'd0,  5'd3,  2'b11, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd2, 32'd1);
    step(11, 1, 5'd0,  5'd0,  2'b00, 5'd9,  1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, 32'd1);
    step(12, 1, 5'd9,  5'd0,  2'b01, 5'd10, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0, 2'd0, 32'd1);
    step(13, 1, 5'd9,  5'd10, 2'b11, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd2, 2'd0, 32'd1);
    step(14, 1, 5'd0,  5'd0,  2'b00, 5'd11, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'd1);
    step(15, 1, 5'd11, 5'd0,  2'b01, 5'd12, 1'b1, 3'd7, 1'b0, 1'b0, 2'd1, 2'd0, 32'd1);
    step(16, 1, 5'd0,  5'd12, 2'b10, 5'd0,  1'b0, 3'd1, 1'b0, 1'b1, 2'd0, 2'd0, 32'd1);
    step(17, 1, 5'd0,  5'd12, 2'b10, 5'd0,  1'b0, 3'd1, 1'b0, 1'b1, 2'd0, 2'd0, 32'd2);
    step(18, 1, 5'd0,  5'd12, 2'b10, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd3, 32'd3);
    step(19, 1, 5'd0,  5'd0,  2'b00, 5'd13, 1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, 32'd3);

    // Reset asserted while the load in stage 1 is stalling a reader.
    drive(1'b1, 5'd13, 5'd0, 2'b01, 5'd0, 1'b0, 3'd1, 1'b0);
    push_exp(1'b1, 2'd0, 2'd0, 32'd3);
    @(negedge clk);
    check_now(20);
    #1 rst_n = 1'b0;
    #1;
    push_exp(1'b0, 2'd0, 2'd0, 32'd0);
    check_now(21);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(22, 1, 5'd13, 5'd0,  2'b01, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'd0);

    if (exp_q.size() != 0) begin
      cmp("leftover_expectations", exp_q.size(), 32'd0);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the in-order RISC-V pipeline.
- Tracks in-flight register writers in a DEPTH-entry shift scoreboard (stage 1 = EX … stage DEPTH = WB).
- For each read port of the instruction in ID, selects the youngest ready forwarding source.
- Raises stall when the youngest matching producer has not yet produced its result (load-use, multi-cycle ops).
- Keeps a saturating stall counter.

Parameters:
- REG_AW, 5, register address width.
- NUM_RD_PORTS, 2, source operands checked per instruction.
- DEPTH, 3, scoreboard stages tracked after ID; 2..7.
- LAT_W, 3, width of latency field; must hold DEPTH.
- SEL_W, $clog2(DEPTH+1), width of one forward-select field.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NUM_RD_PORTS*REG_AW  source addresses; port p at [p*REG_AW +: REG_AW].
- id_rs_used_i  in  NUM_RD_PORTS  port p actually reads its source.
- id_rd_i  in  REG_AW  destination address.
- id_reg_write_i  in  1  instruction writes rd.
- id_lat_i  in  LAT_W  first stage (1..DEPTH) whose register holds the result: ALU=1, load=2.
- flush_i  in  1  kill the ID instruction (branch taken).
- stall_o  out  1  hold IF/ID this cycle.
- fwd_sel_o  out  NUM_RD_PORTS*SEL_W  per port: 0 = register file, k = stage k.
- stall_cnt_o  out  32  saturating count of stall cycles.

Behaviour:
- Entry k (1..DEPTH) holds: v, wr, rd, lat.
- Reset (rst_i=0, asynchronous): all v=0 and stall_cnt_o=0. While the scoreboard is empty, stall_o=0 and fwd_sel_o=0.
- Hit[p][k] is true when all of the following hold:
  - id_rs_used_i[p] and entry k has v and wr;
  - entry k rd == rs_p;
  - rs_p != 0 (x0 never hits).
- Youngest hit (smallest k) decides the port; older hits are ignored.
  - If k >= lat: fwd_sel[p]=k.
  - Else the port is not ready: fwd_sel[p]=0 and raw_stall=1.
- No hit on a port: fwd_sel[p]=0.
- stall_o = raw_stall & id_valid_i & ~flush_i. It is combinational from the registered scoreboard plus ID inputs, with no latency.
- fwd_sel_o is valid whenever id_valid_i=1; it is don't-care when stall_o=1.
- Clock edge, not in reset:
  - Entries k=2..DEPTH load from entry k-1 unconditionally; the pipeline behind ID never stalls.
  - Entry 1 loads {v=1, wr=id_reg_write_i, rd=id_rd_i, lat=id_lat_i} when id_valid_i & ~stall_o & ~flush_i. Otherwise entry 1 gets v=0 (bubble).
  - The entry leaving stage DEPTH is discarded.
- Stall counter: increments by 1 on each edge with stall_o=1; holds at 32'hFFFF_FFFF.
- Flush and stall in the same cycle: flush wins, stall_o=0, bubble inserted, counter unchanged.
- id_lat_i=0 is treated as 1; id_lat_i>DEPTH is treated as DEPTH.
- Write to x0 (rd=0, wr=1) is tracked but never matches.
- Reset asserted mid-operation clears every entry immediately. No forward to a pre-reset producer occurs after reset.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF = 0 constant;
  - typedef sb_entry_t {v, wr, rd, lat};
  - default REG_AW/DEPTH constants.
- One sub-module, hazard_port_match, one instance per read port, generate loop. Inputs: rs, used, scoreboard vector. Outputs: sel, not_ready.
- Top level: scoreboard shift register, stall OR-reduction, counter.

Test Plan:
- After reset, ID issues rs1=5, rs2=6, valid -> stall_o=0, fwd_sel_o=0, stall_cnt_o=0.
- ALU write x5 (lat=1) issued; next cycle ID rs1=5 -> fwd_sel[0]=1, stall_o=0. One cycle later (producer at stage 2) -> fwd_sel[0]=2.
- Load x7 (lat=2) issued; next cycle ID rs2=7 -> stall_o=1 for exactly 1 cycle, stall_cnt_o=1. Then fwd_sel[1]=2, stall_o=0.
- ALU x3 then ALU x3 back-to-back; ID rs1=3 -> fwd_sel[0]=1 (youngest). ID rs1=0 with prior write to x0 -> fwd_sel[0]=0.
- Load x9 issued; ID reads x9 with flush_i=1 -> stall_o=0, entry 1 bubble, counter unchanged. Next cycle ID reads x9 -> fwd_sel=2, no stall.
- Assert rst_i=0 mid-stall with a load in stage 1 -> stall_o=0 and stall_cnt_o=0 immediately. After release, ID reads the old rd -> fwd_sel=0.
